// File: rtl/spi_master_arb.sv
// -----------------------------------------------------------------------------
// spi_master_arb
//
// Round-robin arbiter/sequencer sharing one SPI master core among N_REQ
// single-byte requesters. A requester is granted in IDLE, its command is
// latched, a one-cycle wr_en/rd_en start pulse is issued, and the block waits
// for the matching finish before returning a one-cycle completion pulse.
//
// Build option:
//   SPI_ARB_TIMEOUT_EN - when defined, a 16-bit watchdog limits the time
//                        spent in WAIT to TIMEOUT_CYC cycles and reports
//                        expiry through rsp_err. When undefined, WAIT has no
//                        time limit and rsp_err is always 0.
//
// Ports:
//   sclk          system clock, rising edge
//   rst           asynchronous active-high reset
//   req_valid     per-requester command pending (held until req_ready)
//   req_rw        per-requester op: 1 = read, 0 = write
//   req_wdata     per-requester write byte, slice i = [8i+7:8i]
//   req_div       per-requester SPI divider (0 replaced by DIV_MIN)
//   req_ready     one-hot accept pulse
//   rsp_valid     one-hot completion pulse
//   rsp_rdata     read byte with rsp_valid (0 for writes / timeouts)
//   rsp_err       timeout flag with rsp_valid
//   busy          high whenever the FSM is not in IDLE
//   wr_en, rd_en  start pulses to the SPI master
//   tx_wr_data    write byte to the SPI master (0 for reads)
//   sclk_divider  divider to the SPI master
//   wr_finish     write-done pulse from the SPI master
//   rd_finish     read-done pulse from the SPI master
//   rx_rd_data    read byte from the SPI master, valid with rd_finish
// -----------------------------------------------------------------------------
module spi_master_arb #(
    parameter int unsigned N_REQ       = 2,
    parameter logic [7:0]  DIV_MIN     = 8'h01,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                 sclk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ-1:0]     req_rw,
    input  logic [8*N_REQ-1:0]   req_wdata,
    input  logic [8*N_REQ-1:0]   req_div,
    output logic [N_REQ-1:0]     req_ready,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [7:0]           rsp_rdata,
    output logic                 rsp_err,
    output logic                 busy,
    output logic                 wr_en,
    output logic                 rd_en,
    output logic [7:0]           tx_wr_data,
    output logic [7:0]           sclk_divider,
    input  logic                 wr_finish,
    input  logic                 rd_finish,
    input  logic [7:0]           rx_rd_data
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW    = IDX_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_gnt;
    logic               r_rw;
    logic [7:0]         r_tx;
    logic [7:0]         r_div;
    logic [7:0]         r_rdata;

    logic               w_found;
    logic [IDX_W-1:0]   w_gnt_idx;
    logic [CW-1:0]      w_cand;
    logic [N_REQ-1:0]   w_gnt_oh;
    logic [N_REQ-1:0]   w_rsp_oh;
    logic [7:0]         w_sel_wdata;
    logic [7:0]         w_sel_div;
    logic               w_sel_rw;
    logic               w_match;
    logic               w_timeout;

    // Search upward from the round-robin pointer with wrap; the first
    // requesting index wins. w_cand never exceeds 2*N_REQ-2, so one
    // conditional subtraction is enough to wrap it.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_cand    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_cand = {1'b0, r_ptr} + CW'(k);
            if (w_cand >= CW'(N_REQ)) begin
                w_cand = w_cand - CW'(N_REQ);
            end
            if (!w_found && req_valid[w_cand[IDX_W-1:0]]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_cand[IDX_W-1:0];
            end
        end
    end

    assign w_gnt_oh    = N_REQ'(1) << w_gnt_idx;
    assign w_rsp_oh    = N_REQ'(1) << r_gnt;
    assign w_sel_wdata = req_wdata[{w_gnt_idx, 3'b000} +: 8];
    assign w_sel_div   = req_div[{w_gnt_idx, 3'b000} +: 8];
    assign w_sel_rw    = req_rw[w_gnt_idx];

    // Only the finish that matches the latched direction counts.
    assign w_match = r_rw ? rd_finish : wr_finish;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

    logic [15:0] r_wait_cnt;
    logic        r_err;

    // Cleared while in ISSUE so it reads 0 in the first WAIT cycle.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if (r_state == ST_ISSUE) begin
            r_wait_cnt <= '0;
        end else if (r_state == ST_WAIT) begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
        end
    end

    assign w_timeout = (r_state == ST_WAIT) && (r_wait_cnt == TO_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Finish inputs are deliberately not looked at here.
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_match || w_timeout) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM outputs
    // -------------------------------------------------------------------------
    always_comb begin
        req_ready    = '0;
        rsp_valid    = '0;
        rsp_rdata    = 8'h00;
        rsp_err      = 1'b0;
        wr_en        = 1'b0;
        rd_en        = 1'b0;
        busy         = (r_state != ST_IDLE);
        tx_wr_data   = r_tx;
        sclk_divider = r_div;
        case (r_state)
            ST_IDLE: begin
                // The grant is combinational from req_valid, so it is masked
                // while rst is held to keep every output at 0 in reset.
                if (w_found && !rst) begin
                    req_ready = w_gnt_oh;
                end
            end
            ST_ISSUE: begin
                wr_en = !r_rw;
                rd_en = r_rw;
            end
            ST_DONE: begin
                rsp_valid = w_rsp_oh;
                rsp_rdata = r_rdata;
`ifdef SPI_ARB_TIMEOUT_EN
                rsp_err   = r_err;
`endif
            end
            default: begin
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Latched command, response data and round-robin pointer
    // -------------------------------------------------------------------------
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_rw    <= 1'b0;
            r_tx    <= 8'h00;
            r_div   <= 8'h00;
            r_rdata <= 8'h00;
`ifdef SPI_ARB_TIMEOUT_EN
            r_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_gnt   <= w_gnt_idx;
                        r_rw    <= w_sel_rw;
                        r_tx    <= w_sel_rw ? 8'h00 : w_sel_wdata;
                        r_div   <= (w_sel_div == 8'h00) ? DIV_MIN : w_sel_div;
                        r_rdata <= 8'h00;
`ifdef SPI_ARB_TIMEOUT_EN
                        r_err   <= 1'b0;
`endif
                    end
                end
                ST_WAIT: begin
                    if (w_match) begin
                        if (r_rw) begin
                            r_rdata <= rx_rd_data;
                        end
                    end
`ifdef SPI_ARB_TIMEOUT_EN
                    else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_rdata <= 8'h00;
                    end
`endif
                end
                ST_DONE: begin
                    if (r_gnt == IDX_W'(N_REQ - 1)) begin
                        r_ptr <= '0;
                    end else begin
                        r_ptr <= r_gnt + IDX_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_arb.sv
// -----------------------------------------------------------------------------
// tb_spi_master_arb
//
// Directed bench for spi_master_arb with two requesters. Inputs change on the
// falling edge; outputs are checked 1 ns after the falling edge.
// -----------------------------------------------------------------------------
module tb_spi_master_arb;

    logic        sclk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_rw;
    logic [15:0] req_wdata;
    logic [15:0] req_div;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic        wr_en;
    logic        rd_en;
    logic [7:0]  tx_wr_data;
    logic [7:0]  sclk_divider;
    logic        wr_finish;
    logic        rd_finish;
    logic [7:0]  rx_rd_data;

    int n_cmp;
    int n_bad;

    spi_master_arb #(
        .N_REQ       (2),
        .DIV_MIN     (8'h01),
        .TIMEOUT_CYC (16)
    ) dut (
        .sclk         (sclk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_rw       (req_rw),
        .req_wdata    (req_wdata),
        .req_div      (req_div),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .busy         (busy),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .tx_wr_data   (tx_wr_data),
        .sclk_divider (sclk_divider),
        .wr_finish    (wr_finish),
        .rd_finish    (rd_finish),
        .rx_rd_data   (rx_rd_data)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    initial begin
        #500000;
        $display("FAIL watchdog: got time limit reached want completion");
        $fatal(1);
    end

    task automatic test_reset;
        repeat (2) @(negedge sclk);
        #1;
        n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL rst_req_ready: got %b want 00", req_ready); end
        n_cmp++; if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL rst_rsp_valid: got %b want 00", rsp_valid); end
        n_cmp++; if (rsp_rdata !== 8'h00) begin n_bad++; $display("FAIL rst_rsp_rdata: got %h want 00", rsp_rdata); end
        n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_err: got %b want 0", rsp_err); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if ({wr_en, rd_en} !== 2'b00) begin n_bad++; $display("FAIL rst_en: got %b want 00", {wr_en, rd_en}); end
        n_cmp++; if (tx_wr_data !== 8'h00) begin n_bad++; $display("FAIL rst_tx: got %h want 00", tx_wr_data); end
        n_cmp++; if (sclk_divider !== 8'h00) begin n_bad++; $display("FAIL rst_div: got %h want 00", sclk_divider); end
        @(negedge sclk);
        rst = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL rst_first_grant: got %b want 01", req_ready); end
        @(negedge sclk);
        req_valid = 2'b00;
        #1;
        n_cmp++; if ({wr_en, rd_en} !== 2'b10) begin n_bad++; $display("FAIL rst_first_en: got %b want 10", {wr_en, rd_en}); end
        n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL rst_ready_issue: got %b want 00", req_ready); end
        n_cmp++; if (tx_wr_data !== 8'h11) begin n_bad++; $display("FAIL rst_first_tx: got %h want 11", tx_wr_data); end
        n_cmp++; if (sclk_divider !== 8'h04) begin n_bad++; $display("FAIL rst_first_div: got %h want 04", sclk_divider); end
        @(negedge sclk);
        wr_finish = 1'b1;
        @(negedge sclk);
        wr_finish = 1'b0;
        #1;
        n_cmp++; if (rsp_valid !== 2'b01) begin n_bad++; $display("FAIL rst_first_rsp: got %b want 01", rsp_valid); end
        @(negedge sclk);
    endtask

    task automatic test_write;
        req_valid       = 2'b01;
        req_rw          = 2'b00;
        req_wdata[7:0]  = 8'hA5;
        req_div[7:0]    = 8'h00;
        #1;
        n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL wr_ready: got %b want 01", req_ready); end
        @(negedge sclk);
        req_valid      = 2'b00;
        req_wdata[7:0] = 8'hFF;
        req_div[7:0]   = 8'h33;
        #1;
        n_cmp++; if ({wr_en, rd_en} !== 2'b10) begin n_bad++; $display("FAIL wr_en_pulse: got %b want 10", {wr_en, rd_en}); end
        n_cmp++; if (tx_wr_data !== 8'hA5) begin n_bad++; $display("FAIL wr_tx: got %h want a5", tx_wr_data); end
        n_cmp++; if (sclk_divider !== 8'h01) begin n_bad++; $display("FAIL wr_div_min: got %h want 01", sclk_divider); end
        @(negedge sclk);
        #1;
        n_cmp++; if ({wr_en, rd_en} !== 2'b00) begin n_bad++; $display("FAIL wr_en_low: got %b want 00", {wr_en, rd_en}); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL wr_busy: got %b want 1", busy); end
        repeat (9) @(negedge sclk);
        n_cmp++; if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL wr_early_rsp: got %b want 00", rsp_valid); end
        wr_finish = 1'b1;
        @(negedge sclk);
        wr_finish = 1'b0;
        #1;
        n_cmp++; if (rsp_valid !== 2'b01) begin n_bad++; $display("FAIL wr_rsp_valid: got %b want 01", rsp_valid); end
        n_cmp++; if (rsp_rdata !== 8'h00) begin n_bad++; $display("FAIL wr_rsp_rdata: got %h want 00", rsp_rdata); end
        n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL wr_rsp_err: got %b want 0", rsp_err); end
        n_cmp++; if (tx_wr_data !== 8'hA5) begin n_bad++; $display("FAIL wr_tx_done: got %h want a5", tx_wr_data); end
        @(negedge sclk);
        #1;
        n_cmp++; if ({busy, rsp_valid} !== 3'b000) begin n_bad++; $display("FAIL wr_idle: got %b want 000", {busy, rsp_valid}); end
        n_cmp++; if ({tx_wr_data, sclk_divider} !== 16'hA501) begin n_bad++; $display("FAIL wr_hold_idle: got %h want a501", {tx_wr_data, sclk_divider}); end
    endtask

    task automatic test_read;
        req_valid        = 2'b10;
        req_rw           = 2'b10;
        req_wdata[15:8]  = 8'h77;
        req_div[15:8]    = 8'h20;
        rx_rd_data       = 8'h00;
        #1;
        n_cmp++; if (req_ready !== 2'b10) begin n_bad++; $display("FAIL rd_ready: got %b want 10", req_ready); end
        @(negedge sclk);
        req_valid     = 2'b00;
        req_div[15:8] = 8'h55;
        rd_finish     = 1'b1;
        #1;
        n_cmp++; if ({wr_en, rd_en} !== 2'b01) begin n_bad++; $display("FAIL rd_en_pulse: got %b want 01", {wr_en, rd_en}); end
        n_cmp++; if (tx_wr_data !== 8'h00) begin n_bad++; $display("FAIL rd_tx_zero: got %h want 00", tx_wr_data); end
        n_cmp++; if (sclk_divider !== 8'h20) begin n_bad++; $display("FAIL rd_div: got %h want 20", sclk_divider); end
        @(negedge sclk);
        rd_finish = 1'b0;
        wr_finish = 1'b1;
        #1;
        n_cmp++; if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL rd_issue_finish_ignored: got %b want 00", rsp_valid); end
        n_cmp++; if ({wr_en, rd_en} !== 2'b00) begin n_bad++; $display("FAIL rd_en_low: got %b want 00", {wr_en, rd_en}); end
        @(negedge sclk);
        wr_finish = 1'b0;
        #1;
        n_cmp++; if ({busy, rsp_valid} !== 3'b100) begin n_bad++; $display("FAIL rd_wrong_finish_ignored: got %b want 100", {busy, rsp_valid}); end
        n_cmp++; if (sclk_divider !== 8'h20) begin n_bad++; $display("FAIL rd_div_held: got %h want 20", sclk_divider); end
        @(negedge sclk);
        wr_finish  = 1'b1;
        rd_finish  = 1'b1;
        rx_rd_data = 8'h3C;
        @(negedge sclk);
        wr_finish  = 1'b0;
        rd_finish  = 1'b0;
        rx_rd_data = 8'h00;
        #1;
        n_cmp++; if (rsp_valid !== 2'b10) begin n_bad++; $display("FAIL rd_rsp_valid: got %b want 10", rsp_valid); end
        n_cmp++; if (rsp_rdata !== 8'h3C) begin n_bad++; $display("FAIL rd_rsp_rdata: got %h want 3c", rsp_rdata); end
        n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL rd_rsp_err: got %b want 0", rsp_err); end
        @(negedge sclk);
        #1;
        n_cmp++; if ({busy, rsp_rdata} !== 9'h000) begin n_bad++; $display("FAIL rd_idle: got %h want 000", {busy, rsp_rdata}); end
    endtask

    task automatic test_round_robin;
        logic [1:0] exp_g;
        req_valid  = 2'b11;
        req_rw     = 2'b00;
        rx_rd_data = 8'h99;
        for (int t = 0; t < 4; t++) begin
            exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            n_cmp++; if ({busy, req_ready} !== {1'b0, exp_g}) begin n_bad++; $display("FAIL rr_grant%0d: got %b want %b", t, {busy, req_ready}, {1'b0, exp_g}); end
            @(negedge sclk);
            #1;
            n_cmp++; if ({req_ready, wr_en} !== 3'b001) begin n_bad++; $display("FAIL rr_issue%0d: got %b want 001", t, {req_ready, wr_en}); end
            @(negedge sclk);
            wr_finish = 1'b1;
            #1;
            n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL rr_wait_ready%0d: got %b want 00", t, req_ready); end
            @(negedge sclk);
            wr_finish = 1'b0;
            #1;
            n_cmp++; if ({req_ready, rsp_valid} !== {2'b00, exp_g}) begin n_bad++; $display("FAIL rr_done%0d: got %b want %b", t, {req_ready, rsp_valid}, {2'b00, exp_g}); end
            n_cmp++; if (rsp_rdata !== 8'h00) begin n_bad++; $display("FAIL rr_rdata%0d: got %h want 00", t, rsp_rdata); end
            @(negedge sclk);
        end
        req_valid  = 2'b00;
        rx_rd_data = 8'h00;
    endtask

    task automatic test_reset_midop;
        req_valid      = 2'b01;
        req_rw         = 2'b00;
        req_wdata[7:0] = 8'h5A;
        req_div[7:0]   = 8'h03;
        #1;
        n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL mr_ready0: got %b want 01", req_ready); end
        @(negedge sclk);
        req_valid = 2'b00;
        @(negedge sclk);
        wr_finish = 1'b1;
        @(negedge sclk);
        wr_finish = 1'b0;
        #1;
        n_cmp++; if (rsp_valid !== 2'b01) begin n_bad++; $display("FAIL mr_rsp0: got %b want 01", rsp_valid); end
        @(negedge sclk);
        req_valid     = 2'b10;
        req_rw        = 2'b10;
        req_div[15:8] = 8'h07;
        #1;
        n_cmp++; if (req_ready !== 2'b10) begin n_bad++; $display("FAIL mr_ready1: got %b want 10", req_ready); end
        @(negedge sclk);
        req_valid = 2'b11;
        #1;
        n_cmp++; if (rd_en !== 1'b1) begin n_bad++; $display("FAIL mr_rd_en: got %b want 1", rd_en); end
        @(negedge sclk);
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mr_busy_wait: got %b want 1", busy); end
        rst       = 1'b1;
        rd_finish = 1'b1;
        #1;
        n_cmp++; if ({busy, wr_en, rd_en, req_ready, rsp_valid} !== 7'b0) begin n_bad++; $display("FAIL mr_ctrl_in_rst: got %b want 0000000", {busy, wr_en, rd_en, req_ready, rsp_valid}); end
        n_cmp++; if ({tx_wr_data, sclk_divider} !== 16'h0000) begin n_bad++; $display("FAIL mr_data_in_rst: got %h want 0000", {tx_wr_data, sclk_divider}); end
        @(negedge sclk);
        #1;
        n_cmp++; if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL mr_no_rsp: got %b want 00", rsp_valid); end
        rd_finish = 1'b0;
        rst       = 1'b0;
        req_rw    = 2'b00;
        #1;
        n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL mr_regrant_ptr0: got %b want 01", req_ready); end
        @(negedge sclk);
        req_valid = 2'b00;
        #1;
        n_cmp++; if ({wr_en, tx_wr_data, sclk_divider} !== 17'h15A03) begin n_bad++; $display("FAIL mr_regrant_issue: got %h want 15a03", {wr_en, tx_wr_data, sclk_divider}); end
        @(negedge sclk);
        wr_finish = 1'b1;
        @(negedge sclk);
        wr_finish = 1'b0;
        #1;
        n_cmp++; if (rsp_valid !== 2'b01) begin n_bad++; $display("FAIL mr_regrant_rsp: got %b want 01", rsp_valid); end
        @(negedge sclk);
    endtask

    task automatic test_timeout;
        req_valid    = 2'b01;
        req_rw       = 2'b01;
        req_div[7:0] = 8'h00;
        rx_rd_data   = 8'hEE;
        #1;
        n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL to_ready: got %b want 01", req_ready); end
        @(negedge sclk);
        req_valid = 2'b00;
        #1;
        n_cmp++; if (rd_en !== 1'b1) begin n_bad++; $display("FAIL to_rd_en: got %b want 1", rd_en); end
        @(negedge sclk);
`ifdef SPI_ARB_TIMEOUT_EN
        for (int i = 1; i < 16; i++) begin
            @(negedge sclk);
            #1;
            n_cmp++; if ({busy, rsp_valid} !== 3'b100) begin n_bad++; $display("FAIL to_wait%0d: got %b want 100", i, {busy, rsp_valid}); end
        end
        @(negedge sclk);
        #1;
        n_cmp++; if (rsp_valid !== 2'b01) begin n_bad++; $display("FAIL to_rsp_valid: got %b want 01", rsp_valid); end
        n_cmp++; if (rsp_err !== 1'b1) begin n_bad++; $display("FAIL to_rsp_err: got %b want 1", rsp_err); end
        n_cmp++; if (rsp_rdata !== 8'h00) begin n_bad++; $display("FAIL to_rsp_rdata: got %h want 00", rsp_rdata); end
`else
        for (int i = 1; i <= 120; i++) begin
            @(negedge sclk);
            #1;
            n_cmp++; if ({busy, rsp_valid} !== 3'b100) begin n_bad++; $display("FAIL nto_wait%0d: got %b want 100", i, {busy, rsp_valid}); end
        end
        rd_finish = 1'b1;
        @(negedge sclk);
        rd_finish = 1'b0;
        #1;
        n_cmp++; if (rsp_valid !== 2'b01) begin n_bad++; $display("FAIL nto_rsp_valid: got %b want 01", rsp_valid); end
        n_cmp++; if (rsp_rdata !== 8'hEE) begin n_bad++; $display("FAIL nto_rsp_rdata: got %h want ee", rsp_rdata); end
        n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL nto_rsp_err: got %b want 0", rsp_err); end
`endif
        @(negedge sclk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL to_idle: got %b want 0", busy); end
        rx_rd_data = 8'h00;
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        rst        = 1'b1;
        req_valid  = 2'b11;
        req_rw     = 2'b00;
        req_wdata  = {8'h22, 8'h11};
        req_div    = {8'h09, 8'h04};
        wr_finish  = 1'b0;
        rd_finish  = 1'b0;
        rx_rd_data = 8'h00;

        test_reset;
        test_write;
        test_read;
        test_round_robin;
        test_reset_midop;
        test_timeout;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_master_arb.md
Name: spi_master_arb

Overview:
Round-robin arbiter and sequencer that shares one SPI master between N_REQ requesters. Each requester posts a single-byte write or read command. The block grants one requester at a time and latches its command. It pulses the master's wr_en/rd_en for one cycle, holds tx data and divider stable, then waits for wr_finish/rd_finish and returns completion (plus read data) to the granted requester. It sits between the system-side clients and the SPI master core, all in the sclk domain.

Parameters:
N_REQ, 2, number of requesters (2..8)
DIV_MIN, 8'h01, divider substituted when a requester supplies 8'h00
TIMEOUT_CYC, 1024, watchdog limit in sclk cycles (used only with SPI_ARB_TIMEOUT_EN)

Ports:
sclk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  N_REQ  per-requester command pending; held until req_ready
req_rw  in  N_REQ  per-requester op: 1=read, 0=write
req_wdata  in  8*N_REQ  per-requester write byte; slice i = [8i+7:8i]
req_div  in  8*N_REQ  per-requester SPI clock divider
req_ready  out  N_REQ  one-cycle accept pulse, one-hot
rsp_valid  out  N_REQ  one-cycle completion pulse, one-hot
rsp_rdata  out  8  read byte, valid with rsp_valid (0 for writes)
rsp_err  out  1  timeout flag, valid with rsp_valid
busy  out  1  high in every state except IDLE
wr_en  out  1  to SPI master: write start pulse
rd_en  out  1  to SPI master: read start pulse
tx_wr_data  out  8  to SPI master: write byte
sclk_divider  out  8  to SPI master: divider
wr_finish  in  1  from SPI master: write done pulse
rd_finish  in  1  from SPI master: read done pulse
rx_rd_data  in  8  from SPI master: read byte, valid with rd_finish

Behaviour:
- One clock (sclk); reset is asynchronous and active-high (rst). In reset, every output is 0, FSM=IDLE, RR pointer=0, and latched command/grant regs are cleared.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any req_valid, pick the first set bit searching upward from the pointer with wrap. Latch grant index g, req_rw[g], req_wdata[g], and req_div[g] (0 replaced by DIV_MIN). Pulse req_ready[g] this cycle, then go to ISSUE. If none are set, stay.
- ISSUE (1 cycle): drive exactly one of wr_en/rd_en high, per latched rw. tx_wr_data and sclk_divider show latched values from ISSUE through DONE. For reads, tx_wr_data=0. Finish inputs are ignored in ISSUE. Go to WAIT.
- WAIT: wr_en/rd_en low. Only the matching finish (wr_finish for a write, rd_finish for a read) advances the FSM; a non-matching finish is ignored. On a read match, capture rx_rd_data. Go to DONE.
- DONE (1 cycle): pulse rsp_valid[g] with rsp_rdata and rsp_err. Set pointer = (g+1) mod N_REQ. Go to IDLE.
- Latency: grant in cycle T; en in T+1; finish seen in cycle F ≥ T+2; rsp_valid in F+1. The next grant is no earlier than F+2.
- tx_wr_data and sclk_divider keep their last values in IDLE; they are not cleared.
- Requester inputs are sampled only in IDLE. Changes after req_ready have no effect on the running transaction.
- If req_valid[g] drops before the grant, it is not granted. No pulse is ever emitted for a requester that is not requesting.
- Simultaneous wr_finish and rd_finish in WAIT: only the matching one counts.
- Reset mid-operation: immediate return to IDLE with no rsp_valid. The SPI master is reset by the same rst.

Optional Feature:
SPI_ARB_TIMEOUT_EN.
- Defined: a 16-bit counter clears on entry to WAIT and increments each WAIT cycle. When it reaches TIMEOUT_CYC-1 with no matching finish, the FSM goes to DONE with rsp_err=1 and rsp_rdata=0. The pointer advances normally.
- Not defined: no counter, WAIT has no time limit, and rsp_err is tied to 0.

Test Plan:
1. Reset with req_valid=2'b11 held: all outputs 0 and busy=0. Release rst: req_ready=2'b01 in the first IDLE cycle, wr_en or rd_en high the next cycle.
2. Req0 write 8'hA5, div 8'h00: wr_en high 1 cycle, tx_wr_data=8'hA5, sclk_divider=8'h01. wr_finish 10 cycles later gives rsp_valid=2'b01 the next cycle, rsp_rdata=0.
3. Req1 read: rd_en pulse, tx_wr_data=0. rd_finish with rx_rd_data=8'h3C gives rsp_valid=2'b10 and rsp_rdata=8'h3C. A wr_finish injected during WAIT is ignored.
4. Both requesters continuously valid for 4 transactions: grants alternate 01,10,01,10, with no grant while busy=1.
5. Assert rst during WAIT: outputs 0 immediately, no rsp_valid. After release, the pending requester is re-granted starting from pointer 0.
6. SPI_ARB_TIMEOUT_EN, TIMEOUT_CYC=16, no finish: rsp_valid 16 cycles after entering WAIT with rsp_err=1. Without the macro, busy stays 1 for 100+ cycles.
